// File: rtl/btn_pulse_debounce_if.sv
// Button front-end bundle: raw button in, strobe/level/count out.
// master drives the raw button; slave is the debouncer side.
interface btn_pulse_debounce_if #(
    parameter int CNT_W = 8
);
    logic             btn_in;
    logic             ena_pulse;
    logic             btn_level;
    logic [CNT_W-1:0] pulse_count;

    modport master (
        output btn_in,
        input  ena_pulse,
        input  btn_level,
        input  pulse_count
    );

    modport slave (
        input  btn_in,
        output ena_pulse,
        output btn_level,
        output pulse_count
    );
endinterface

// File: rtl/btn_pulse_debounce.sv
// Button synchroniser + debouncer emitting one enable strobe per press.
// Optional auto-repeat while held: define AUTOREPEAT_EN.
module btn_pulse_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 8,
    parameter int REPEAT_PERIOD   = 3,
    parameter int CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    btn_pulse_debounce_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        RELEASE_CHK
    } state_e;

    localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    logic             s1_q;
    logic             btn_s_q;
    state_e           state_q, state_d;
    logic [DW-1:0]    db_cnt_q, db_cnt_d;
    logic             ena_q, ena_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             enter_held;
    logic             hold_tick;

`ifdef AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                          REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW = $clog2(RMAX) + 1;
    localparam logic [RW-1:0] RPT_DLY = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_PER = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0] rpt_q, rpt_d;
    logic          first_q, first_d;
`else
    logic unused_rpt;
    assign unused_rpt = ^{enter_held, hold_tick,
                          REPEAT_DELAY, REPEAT_PERIOD};
`endif

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        ena_d      = 1'b0;
        level_d    = level_q;
        count_d    = count_q;
        enter_held = 1'b0;
        hold_tick  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (btn_s_q) begin
                    state_d  = PRESS_CHK;
                    db_cnt_d = '0;
                end
            end
            PRESS_CHK: begin
                if (!btn_s_q) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d    = HELD;
                    level_d    = 1'b1;
                    ena_d      = 1'b1;
                    count_d    = count_q + 1'b1;
                    enter_held = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s_q) begin
                    state_d  = RELEASE_CHK;
                    db_cnt_d = '0;
                end else begin
                    hold_tick = 1'b1;
                end
            end
            RELEASE_CHK: begin
                if (btn_s_q) begin
                    state_d    = HELD;
                    enter_held = 1'b1;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d = IDLE;
                    level_d = 1'b0;
                end else begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef AUTOREPEAT_EN
        rpt_d   = rpt_q;
        first_d = first_q;
        // Every entry to HELD restarts the initial delay.
        if (enter_held) begin
            rpt_d   = '0;
            first_d = 1'b0;
        end else if (hold_tick) begin
            if (!first_q && rpt_q == RPT_DLY) begin
                ena_d   = 1'b1;
                count_d = count_q + 1'b1;
                rpt_d   = '0;
                first_d = 1'b1;
            end else if (first_q && rpt_q == RPT_PER) begin
                ena_d   = 1'b1;
                count_d = count_q + 1'b1;
                rpt_d   = '0;
            end else begin
                rpt_d = rpt_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q     <= 1'b0;
            btn_s_q  <= 1'b0;
            state_q  <= IDLE;
            db_cnt_q <= '0;
            ena_q    <= 1'b0;
            level_q  <= 1'b0;
            count_q  <= '0;
        end else begin
            s1_q     <= bus.btn_in;
            btn_s_q  <= s1_q;
            state_q  <= state_d;
            db_cnt_q <= db_cnt_d;
            ena_q    <= ena_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end

`ifdef AUTOREPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rpt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            rpt_q   <= rpt_d;
            first_q <= first_d;
        end
    end
`endif

    assign bus.ena_pulse   = ena_q;
    assign bus.btn_level   = level_q;
    assign bus.pulse_count = count_q;

endmodule

// File: tb/tb_btn_pulse_debounce.sv
// Directed bench for btn_pulse_debounce at default parameters.
// Inputs change 1 time unit after each rising edge; outputs sampled there.
module tb_btn_pulse_debounce;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    int   npulse = 0;
    logic [31:0] mask;

    btn_pulse_debounce_if #(.CNT_W(8)) bus ();

    btn_pulse_debounce dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        if (bus.ena_pulse === 1'b1) npulse++;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.btn_in = 1'b0;
        #1;
        chk("rst_ena", 32'(bus.ena_pulse), 0);
        chk("rst_level", 32'(bus.btn_level), 0);
        chk("rst_count", 32'(bus.pulse_count), 0);
        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        // clean press
        npulse = 0;
        bus.btn_in = 1'b1;
        repeat (6) step();
        chk("t1_ena_e5", 32'(bus.ena_pulse), 0);
        chk("t1_lvl_e5", 32'(bus.btn_level), 0);
        step();
        chk("t1_ena_e6", 32'(bus.ena_pulse), 1);
        chk("t1_lvl_e6", 32'(bus.btn_level), 1);
        chk("t1_cnt_e6", 32'(bus.pulse_count), 1);
        step();
        chk("t1_ena_e7", 32'(bus.ena_pulse), 0);
        repeat (12) step();
        bus.btn_in = 1'b0;
        repeat (6) step();
        chk("t1_rel_lvl_e5", 32'(bus.btn_level), 1);
        step();
        chk("t1_rel_lvl_e6", 32'(bus.btn_level), 0);
        repeat (3) step();
        chk("t1_npulse", 32'(npulse), 1);
        chk("t1_cnt", 32'(bus.pulse_count), 1);

        // bouncy press
        npulse = 0;
        repeat (5) begin
            bus.btn_in = 1'b1;
            step();
            step();
            bus.btn_in = 1'b0;
            step();
        end
        bus.btn_in = 1'b1;
        repeat (6) step();
        chk("t2_npulse_pre", 32'(npulse), 0);
        chk("t2_ena_e5", 32'(bus.ena_pulse), 0);
        step();
        chk("t2_ena_e6", 32'(bus.ena_pulse), 1);
        chk("t2_cnt", 32'(bus.pulse_count), 2);

        // release glitch while held
        repeat (5) step();
        npulse = 0;
        bus.btn_in = 1'b0;
        step();
        step();
        bus.btn_in = 1'b1;
        repeat (10) step();
        chk("t3_lvl", 32'(bus.btn_level), 1);
        chk("t3_npulse", 32'(npulse), 0);
        chk("t3_cnt", 32'(bus.pulse_count), 2);
        bus.btn_in = 1'b0;
        repeat (8) step();
        chk("t3_rel_lvl", 32'(bus.btn_level), 0);

        // reset during PRESS_CHK
        bus.btn_in = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        #1;
        chk("t4_rst_ena", 32'(bus.ena_pulse), 0);
        chk("t4_rst_lvl", 32'(bus.btn_level), 0);
        chk("t4_rst_cnt", 32'(bus.pulse_count), 0);
        step();
        step();
        reset = 1'b0;
        npulse = 0;
        repeat (6) step();
        chk("t4_ena_e5", 32'(bus.ena_pulse), 0);
        chk("t4_lvl_e5", 32'(bus.btn_level), 0);
        step();
        chk("t4_ena_e6", 32'(bus.ena_pulse), 1);
        chk("t4_cnt", 32'(bus.pulse_count), 1);
        repeat (6) step();
        chk("t4_npulse", 32'(npulse), 1);
        bus.btn_in = 1'b0;
        repeat (8) step();

        // counter wrap
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
        npulse = 0;
        for (int i = 0; i < 256; i++) begin
            bus.btn_in = 1'b1;
            repeat (8) step();
            bus.btn_in = 1'b0;
            repeat (8) step();
            if (i == 254) chk("t5_cnt_255", 32'(bus.pulse_count), 255);
        end
        chk("t5_cnt_wrap", 32'(bus.pulse_count), 0);
        chk("t5_npulse", 32'(npulse), 256);

        // long hold: auto-repeat when enabled
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
        bus.btn_in = 1'b1;
        repeat (7) step();
        chk("t6_press", 32'(bus.ena_pulse), 1);
        mask = '0;
        for (int i = 1; i <= 30; i++) begin
            if (i == 18) bus.btn_in = 1'b0;
            step();
            if (bus.ena_pulse === 1'b1) mask[i] = 1'b1;
        end
`ifdef AUTOREPEAT_EN
        chk("t6_mask", mask, 32'h0002_4900);
        chk("t6_cnt", 32'(bus.pulse_count), 5);
`else
        chk("t6_mask", mask, 32'h0);
        chk("t6_cnt", 32'(bus.pulse_count), 1);
`endif
        chk("t6_lvl", 32'(bus.btn_level), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
